// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: EX/MEM and MEM/WB registers plus handshaked data-memory port
//
// Purpose: latches the EX-stage result, runs one data-memory access per
// load/store (IDLE/ACCESS FSM with a timeout), produces the MEM-stage
// forwarding value and the MEM/WB write-back bundle, and stalls the front
// of the pipeline while an access is outstanding.
//
// Ports:
//   clk, reset_n           clock; synchronous reset, active-high (1 = reset)
//   ex_*                   EX-stage result and control, loaded when stall=0
//   d_address, d_write_data, d_read_m, d_write_m
//                          data-memory request, held stable during ACCESS
//   d_read_data, d_ready   memory response; d_ready is a one-cycle strobe
//   stall                  freezes PC, IF/ID and ID/EX
//   mem_reg_write_data, mem_write_target, mem_fwd_valid
//                          MEM-stage forwarding value
//   wb_reg_write_data, wb_write_target, wb_reg_write
//                          MEM/WB register
//   mem_error              one-cycle pulse when an access is aborted on timeout

module mem_access_stage #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] ex_pc_val,
    input  logic [WORD_SIZE-1:0] ex_alu_out,
    input  logic [WORD_SIZE-1:0] ex_store_data,
    input  logic [1:0]           ex_write_target,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic [1:0]           ex_reg_write_src,
    input  logic                 ex_reg_write,
    output logic [WORD_SIZE-1:0] d_address,
    output logic [WORD_SIZE-1:0] d_write_data,
    output logic                 d_read_m,
    output logic                 d_write_m,
    input  logic [WORD_SIZE-1:0] d_read_data,
    input  logic                 d_ready,
    output logic                 stall,
    output logic [WORD_SIZE-1:0] mem_reg_write_data,
    output logic [1:0]           mem_write_target,
    output logic                 mem_fwd_valid,
    output logic [WORD_SIZE-1:0] wb_reg_write_data,
    output logic [1:0]           wb_write_target,
    output logic                 wb_reg_write,
    output logic                 mem_error
);

    typedef enum logic {IDLE, ACCESS} stageState_t;

    // Count value on the last ACCESS cycle allowed before the abort.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    stageState_t state, nextState;

    // EX/MEM register
    logic [WORD_SIZE-1:0] pcVal, aluOut, storeData;
    logic [1:0]           writeTarget, regWriteSrc;
    logic                 memRead, memWrite, regWrite;

    logic [7:0]           count;
    logic                 inAccess, timeoutHit, wbEnable;
    logic [WORD_SIZE-1:0] resultData;

    assign inAccess   = (state == ACCESS);
    // A d_ready on the limit cycle wins over the abort.
    assign timeoutHit = inAccess && (count == LIMIT) && !d_ready;
    assign stall      = inAccess && !d_ready && !timeoutHit;
    assign mem_error  = timeoutHit;

    // Read+write together is treated as a write.
    assign d_write_m    = inAccess && memWrite;
    assign d_read_m     = inAccess && memRead && !memWrite;
    assign d_address    = aluOut;
    assign d_write_data = storeData;

    assign mem_write_target   = writeTarget;
    assign mem_reg_write_data = (regWriteSrc == 2'd2) ? pcVal : aluOut;
    // Load data does not exist yet in MEM, so loads are never forwarded here.
    assign mem_fwd_valid      = regWrite && (regWriteSrc != 2'd1);

    // Only a completing instruction writes back; stalls and aborts send a bubble.
    assign wbEnable = !stall && !timeoutHit && regWrite;

    always_comb begin
        nextState  = state;
        resultData = aluOut;
        if (!stall) begin
            nextState = (ex_mem_read || ex_mem_write) ? ACCESS : IDLE;
        end
        case (regWriteSrc)
            2'd1:    resultData = d_read_data;
            2'd2:    resultData = pcVal;
            default: resultData = aluOut;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state             <= IDLE;
            pcVal             <= '0;
            aluOut            <= '0;
            storeData         <= '0;
            writeTarget       <= '0;
            regWriteSrc       <= '0;
            memRead           <= 1'b0;
            memWrite          <= 1'b0;
            regWrite          <= 1'b0;
            count             <= '0;
            wb_reg_write      <= 1'b0;
            wb_reg_write_data <= '0;
            wb_write_target   <= '0;
        end else begin
            state <= nextState;
            // Stall only occurs in ACCESS, so any completion or abort clears it.
            count <= stall ? count + 8'd1 : 8'd0;
            if (!stall) begin
                pcVal       <= ex_pc_val;
                aluOut      <= ex_alu_out;
                storeData   <= ex_store_data;
                writeTarget <= ex_write_target;
                regWriteSrc <= ex_reg_write_src;
                memRead     <= ex_mem_read;
                memWrite    <= ex_mem_write;
                regWrite    <= ex_reg_write;
            end
            wb_reg_write <= wbEnable;
            if (wbEnable) begin
                wb_reg_write_data <= resultData;
                wb_write_target   <= writeTarget;
            end
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline; sits downstream of the EX stage.
- Owns the EX/MEM and MEM/WB pipeline registers and drives the handshaked data-memory port.
- Consumes EX results and control (ALU result, store data, write target, MemRead/MemWrite, RegWriteSrc/RegWrite).
- Produces the MEM-stage forwarding value, the write-back bundle, and a pipeline stall while a memory access is outstanding.

Parameters:
WORD_SIZE, 16, datapath width.
TIMEOUT, 15, max ACCESS cycles waiting for d_ready before abort; range 1..255.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  synchronous reset, active-high: asserted when 1, sampled on rising clk.
ex_pc_val  input  WORD_SIZE  PC+1 of the EX instruction (link value).
ex_alu_out  input  WORD_SIZE  ALU result; also the memory address.
ex_store_data  input  WORD_SIZE  forwarded Rt value for stores.
ex_write_target  input  2  destination register.
ex_mem_read  input  1  load.
ex_mem_write  input  1  store.
ex_reg_write_src  input  2  0=ALU, 1=memory, 2=PC link, 3=reserved (treated as 0).
ex_reg_write  input  1  writes the register file.
d_address  output  WORD_SIZE  memory address.
d_write_data  output  WORD_SIZE  store data.
d_read_m  output  1  read request.
d_write_m  output  1  write request.
d_read_data  input  WORD_SIZE  load data; valid when d_ready=1.
d_ready  input  1  one-cycle completion strobe from memory.
stall  output  1  freezes PC, IF/ID and ID/EX.
mem_reg_write_data  output  WORD_SIZE  forwarding value.
mem_write_target  output  2  forwarding target.
mem_fwd_valid  output  1  forwarding value is usable.
wb_reg_write_data  output  WORD_SIZE  MEM/WB data.
wb_write_target  output  2  MEM/WB target.
wb_reg_write  output  1  MEM/WB write enable.
mem_error  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset:
  - All registers, outputs and counter go to 0.
  - FSM goes to IDLE.
  - Any outstanding request drops on the cycle after reset is sampled.
- FSM states: IDLE and ACCESS; the state is registered.
- EX/MEM load:
  - The EX/MEM register loads all ex_* inputs on an edge where stall=0.
  - If the loaded instruction has ex_mem_read or ex_mem_write set, the next state is ACCESS; otherwise IDLE.
  - If both read and write are set, the operation is a write.
- ACCESS state:
  - d_read_m or d_write_m held high; d_address = latched ALU result; d_write_data = latched store data.
  - Request lines stay stable until d_ready or abort.
  - In IDLE, both request lines are 0.
- Stall:
  - stall = (state==ACCESS) && !d_ready && !timeout_hit.
  - The signal is combinational, so best case a memory op costs one ACCESS cycle with no stall.
- d_ready in ACCESS:
  - The MEM/WB register captures the result that edge (load data when src=1).
  - EX/MEM accepts the next instruction on the same edge.
  - If that next instruction is also a memory op, ACCESS is re-entered back-to-back with the counter cleared.
- d_ready outside ACCESS: ignored.
- Timeout:
  - The counter increments each ACCESS cycle without d_ready.
  - timeout_hit = (count == TIMEOUT-1) && !d_ready.
  - On timeout_hit: mem_error pulses for that cycle, a bubble goes to MEM/WB, EX/MEM accepts the next instruction, and the counter clears.
  - d_ready on the same cycle as the limit counts as success.
- Write-back data select (latched src): 0 → ALU result, 1 → d_read_data, 2 → PC link, 3 → ALU result.
- Non-completing cycles:
  - While stall=1, MEM/WB loads a bubble (wb_reg_write=0) so no duplicate register write occurs.
  - A store completion writes wb_reg_write = latched reg_write (normally 0).
- Forwarding:
  - mem_write_target = latched target.
  - mem_reg_write_data = PC link when src=2, else ALU result.
  - mem_fwd_valid = latched reg_write && src!=1; load results are not forwarded from MEM.
- Reset mid-access: the access is abandoned, no mem_error, no write-back.

Test Plan:
- ALU op: ex_alu_out=0x1234, target=2, reg_write=1, src=0 → stall never high; mem_fwd_valid=1 with data 0x1234; one cycle later wb_reg_write=1, data 0x1234, target 2.
- Load with 3-cycle memory: ex_alu_out=0x0040, read=1, d_ready on 3rd ACCESS cycle with data 0xBEEF → d_read_m=1 and d_address=0x0040 for 3 cycles; stall=1 for 2 cycles; then wb data 0xBEEF, target as given; mem_fwd_valid=0 throughout.
- Store then load back-to-back, d_ready immediate both times: store addr 0x0010 data 0x5555, then load 0x0010 → d_write_m for 1 cycle then d_read_m for 1 cycle; stall never high; store writes no register.
- JAL link: ex_pc_val=0x0021, src=2, target=2 → mem_reg_write_data=0x0021 with mem_fwd_valid=1; wb data 0x0021.
- Timeout with TIMEOUT=4: load, d_ready never asserted → stall high 3 cycles; mem_error pulses on the 4th ACCESS cycle; wb_reg_write stays 0; the next instruction proceeds.
- Reset mid-access: assert reset_n during the 2nd ACCESS cycle → next cycle d_read_m=0, stall=0, all wb outputs 0, mem_error=0.
